// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle for the hazard unit. The pipeline holds the master
// modport (it supplies stage fields); the hazard unit holds the slave modport.
interface hazard_unit_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_muldiv;
    logic        id_is_div;
    logic        id_reads_hilo;
    logic [4:0]  idex_rs;
    logic [4:0]  idex_rt;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic        ex_branch_taken;

    logic        stall;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        muldiv_busy;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_muldiv, id_is_div, id_reads_hilo,
               idex_rs, idex_rt, idex_mem_read, idex_rd,
               exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write,
               ex_branch_taken,
        input  stall, pc_write, ifid_write, ifid_flush, idex_flush,
               forward_a, forward_b, muldiv_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_muldiv, id_is_div, id_reads_hilo,
               idex_rs, idex_rt, idex_mem_read, idex_rd,
               exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write,
               ex_branch_taken,
        output stall, pc_write, ifid_write, ifid_flush, idex_flush,
               forward_a, forward_b, muldiv_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection for the five-stage MIPS pipeline: load-use and HI/LO stalls,
// branch flushes, EX operand forwarding and the mul/div busy timer.
module hazard_unit #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_unit_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_stall_cycles;

    logic             w_busy;
    logic             w_lu;
    logic             w_hh;
    logic             w_stall;
    logic             w_issue;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    assign w_busy = (r_state == BUSY);

    assign w_lu = bus.idex_mem_read && (bus.idex_rd != '0) &&
                  ((bus.idex_rd == bus.id_rs) ||
                   (bus.id_uses_rt && (bus.idex_rd == bus.id_rt)));

    // Covers both the HI/LO data dependency and the single shared mul/div unit.
    assign w_hh = w_busy && (bus.id_reads_hilo || bus.id_muldiv);

    // A taken branch squashes the ID instruction, so its hazard no longer matters.
    assign w_stall = (w_lu || w_hh) && !bus.ex_branch_taken;
    assign w_issue = bus.id_muldiv && !w_stall && !bus.ex_branch_taken;

    always_comb begin
        w_fwd_a = 2'b00;
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.idex_rs))
            w_fwd_a = 2'b10;
        else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.idex_rs))
            w_fwd_a = 2'b01;
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.idex_rt))
            w_fwd_b = 2'b10;
        else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.idex_rt))
            w_fwd_b = 2'b01;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= BUSY;
                        r_cnt   <= bus.id_is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                BUSY: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stall_cycles <= '0;
        else if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign bus.stall        = w_stall;
    assign bus.pc_write     = !w_stall;
    assign bus.ifid_write   = !w_stall;
    assign bus.ifid_flush   = bus.ex_branch_taken;
    assign bus.idex_flush   = bus.ex_branch_taken;
    assign bus.forward_a    = w_fwd_a;
    assign bus.forward_b    = w_fwd_b;
    assign bus.muldiv_busy  = w_busy;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
